// File: rtl/uncached_mem_resp.sv
// Uncached data-memory responder: serves one load/store/LL/SC from EX1
// as a single AXI4-Lite transaction and owns the LLbit used by SC.
module uncached_mem_resp (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        pipe_rvalid,
  input  logic        pipe_wvalid,
  input  logic        pipe_op,
  input  logic [3:0]  pipe_write_type,
  input  logic [31:0] pipe_addr,
  input  logic [31:0] pipe_wdata,
  input  logic        pipe_is_atom,
  input  logic        llbit_clear,
  output logic        pipe_rready,
  output logic        pipe_wready,
  output logic [31:0] pipe_rdata,
  output logic        llbit,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic [31:0] m_awaddr,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic        m_bvalid,
  output logic        m_bready
);

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_AW_W, S_B, S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic        atom_q, atom_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        llbit_q, llbit_d;
  logic        req_wr;

  // State and captured-request registers; reset abandons any transaction
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      atom_q    <= 1'b0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      llbit_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      atom_q    <= atom_d;
      wstrb_q   <= wstrb_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      llbit_q   <= llbit_d;
    end
  end

  // Next-state: request capture, bus handshakes, result and LLbit update
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    atom_d    = atom_q;
    wstrb_d   = wstrb_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    llbit_d   = llbit_q;
    // A lone valid names the direction; with both set, pipe_op decides
    req_wr    = (pipe_rvalid & pipe_wvalid) ? pipe_op : pipe_wvalid;

    unique case (state_q)
      S_IDLE: begin
        if (pipe_rvalid | pipe_wvalid) begin
          addr_d    = pipe_addr[31:2];
          wr_d      = req_wr;
          atom_d    = pipe_is_atom;
          wstrb_d   = pipe_write_type << pipe_addr[1:0];
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          case (pipe_write_type)
            4'b0001: wdata_d = {4{pipe_wdata[7:0]}};
            4'b0011: wdata_d = {2{pipe_wdata[15:0]}};
            default: wdata_d = pipe_wdata;
          endcase
          if (!req_wr) begin
            state_d = S_AR;
          end else if (pipe_is_atom && !llbit_q) begin
            // SC without reservation fails immediately, no bus traffic
            rdata_d = '0;
            state_d = S_RESP;
          end else begin
            state_d = S_AW_W;
          end
        end
      end
      S_AR: begin
        if (m_arready) state_d = S_R;
      end
      S_R: begin
        if (m_rvalid) begin
          rdata_d = m_rdata;
          state_d = S_RESP;
        end
      end
      S_AW_W: begin
        // AW and W complete independently; both may finish in one cycle
        aw_done_d = aw_done_q | m_awready;
        w_done_d  = w_done_q | m_wready;
        if (aw_done_d && w_done_d) state_d = S_B;
      end
      S_B: begin
        if (m_bvalid) begin
          rdata_d = {31'b0, atom_q};
          state_d = S_RESP;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (llbit_clear) begin
      llbit_d = 1'b0;
    end else if (state_q == S_RESP && atom_q) begin
      // LL completion sets the reservation, SC completion consumes it
      llbit_d = ~wr_q;
    end
  end

  assign m_araddr    = {addr_q, 2'b00};
  assign m_awaddr    = {addr_q, 2'b00};
  assign m_wdata     = wdata_q;
  assign m_wstrb     = wstrb_q;
  assign m_arvalid   = (state_q == S_AR);
  assign m_rready    = (state_q == S_R);
  assign m_awvalid   = (state_q == S_AW_W) && !aw_done_q;
  assign m_wvalid    = (state_q == S_AW_W) && !w_done_q;
  assign m_bready    = (state_q == S_B);
  assign pipe_rready = (state_q == S_RESP) && !wr_q;
  assign pipe_wready = (state_q == S_RESP) && wr_q;
  assign pipe_rdata  = rdata_q;
  assign llbit       = llbit_q;

endmodule
